// File: rtl/pdp11_trace_buffer.sv
// -----------------------------------------------------------------------------
// pdp11_trace_buffer
//
// Instruction/result trace capture for the PDP-11 core. Each decode event
// (PC + instruction word) is paired with the next execute event (ALU result)
// and stored as one entry in a circular buffer. Capture can free-run with
// wrap, stop when the buffer fills, or stop a fixed number of entries after
// an opcode trigger. Once capture has stopped the buffer is read out
// oldest-first.
//
// Ports:
//   clock, reset               sole clock (rising edge), synchronous active-high reset
//   arm, stop                  start capture (IDLE/DONE), force DONE (CAPTURE/POST)
//   mode, trig_en              0 = wrap / 1 = stop when full; trigger enable (sampled on arm)
//   trig_mask, trig_value      opcode trigger: (instr & mask) == value
//   fetch_valid/pc/instr       decode event
//   result_valid, alu_result   execute event
//   rd_en                      readout request (DONE only)
//   rd_valid, rd_pc, rd_instr,
//   rd_result, rd_has_result   readout data, one cycle after an accepted rd_en
//   state_o                    0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
//   count                      valid entries, saturating at DEPTH
//   overflow                   oldest entry has been overwritten
//   orphan_cnt                 results seen with no pending fetch (saturating)
// -----------------------------------------------------------------------------
module pdp11_trace_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     mode,
    input  logic                     trig_en,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic                     fetch_valid,
    input  logic [DATA_W-1:0]        fetch_pc,
    input  logic [DATA_W-1:0]        fetch_instr,
    input  logic                     result_valid,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_instr,
    output logic [DATA_W-1:0]        rd_result,
    output logic                     rd_has_result,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               orphan_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * DATA_W + 1;

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       post_rem_q, post_rem_d;
    logic [CW-1:0]       rd_index_q, rd_index_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          orphan_q, orphan_d;
    logic                pending_q, pending_d;
    logic [DATA_W-1:0]   stage_pc_q, stage_pc_d;
    logic [DATA_W-1:0]   stage_instr_q, stage_instr_d;
    logic                mode_q, mode_d;
    logic                trig_en_q, trig_en_d;
    logic                rd_valid_q, rd_valid_d;
    logic [EW-1:0]       rd_entry_q;

    // Entry layout: {pc, instr, result, has_result}
    logic [EW-1:0]       mem [DEPTH];

    logic                wr_en;
    logic [EW-1:0]       wr_entry;
    logic                rd_accept;
    logic [AW-1:0]       rd_addr;
    logic                capturing;
    logic                trig_hit;
    logic                done_full;
    logic                done_post;

    assign capturing = (state_q == S_CAPTURE) || (state_q == S_POST);

    // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
    assign rd_addr = (overflow_q ? wr_ptr_q : '0) + rd_index_q[AW-1:0];

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        post_rem_d    = post_rem_q;
        rd_index_d    = rd_index_q;
        overflow_d    = overflow_q;
        orphan_d      = orphan_q;
        pending_d     = pending_q;
        stage_pc_d    = stage_pc_q;
        stage_instr_d = stage_instr_q;
        mode_d        = mode_q;
        trig_en_d     = trig_en_q;
        rd_valid_d    = 1'b0;
        wr_en         = 1'b0;
        wr_entry      = '0;
        rd_accept     = 1'b0;
        trig_hit      = 1'b0;
        done_full     = 1'b0;
        done_post     = 1'b0;

        if (stop && capturing) begin
            // Any staged fetch is dropped; inputs in this cycle are ignored.
            state_d   = S_DONE;
            pending_d = 1'b0;
        end else if (arm && !capturing) begin
            state_d    = S_CAPTURE;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            orphan_d   = '0;
            pending_d  = 1'b0;
            rd_index_d = '0;
            mode_d     = mode;
            trig_en_d  = trig_en;
        end else if (capturing) begin
            // Pairing of decode and execute events through the staging register.
            if (result_valid && pending_q) begin
                wr_en     = 1'b1;
                wr_entry  = {stage_pc_q, stage_instr_q, alu_result, 1'b1};
                pending_d = fetch_valid;
            end else if (result_valid) begin
                if (orphan_q != 8'hFF) begin
                    orphan_d = orphan_q + 8'd1;
                end
                pending_d = fetch_valid;
            end else if (fetch_valid && pending_q) begin
                // A second fetch before any result: flush the staged one unpaired.
                wr_en    = 1'b1;
                wr_entry = {stage_pc_q, stage_instr_q, {DATA_W{1'b0}}, 1'b0};
            end else if (fetch_valid) begin
                pending_d = 1'b1;
            end

            if (fetch_valid) begin
                stage_pc_d    = fetch_pc;
                stage_instr_d = fetch_instr;
            end

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                if (mode_q && (count_q == FULL - CW'(1))) begin
                    done_full = 1'b1;
                end
                if (state_q == S_POST) begin
                    post_rem_d = post_rem_q - CW'(1);
                    if (post_rem_q == CW'(1)) begin
                        done_post = 1'b1;
                    end
                end
            end

            trig_hit = (state_q == S_CAPTURE) && trig_en_q && fetch_valid &&
                       ((fetch_instr & trig_mask) == trig_value);

            if (done_full || done_post) begin
                state_d = S_DONE;
            end else if (trig_hit) begin
                state_d    = S_POST;
                post_rem_d = POST_LOAD;
            end
        end else if ((state_q == S_DONE) && rd_en && (rd_index_q < count_q)) begin
            rd_accept  = 1'b1;
            rd_valid_d = 1'b1;
            rd_index_d = rd_index_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            post_rem_q    <= '0;
            rd_index_q    <= '0;
            overflow_q    <= 1'b0;
            orphan_q      <= '0;
            pending_q     <= 1'b0;
            stage_pc_q    <= '0;
            stage_instr_q <= '0;
            mode_q        <= 1'b0;
            trig_en_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_entry_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            post_rem_q    <= post_rem_d;
            rd_index_q    <= rd_index_d;
            overflow_q    <= overflow_d;
            orphan_q      <= orphan_d;
            pending_q     <= pending_d;
            stage_pc_q    <= stage_pc_d;
            stage_instr_q <= stage_instr_d;
            mode_q        <= mode_d;
            trig_en_q     <= trig_en_d;
            rd_valid_q    <= rd_valid_d;
            if (rd_accept) begin
                rd_entry_q <= mem[rd_addr];
            end
        end
    end

    // Trace storage; no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_valid      = rd_valid_q;
    assign rd_pc         = rd_entry_q[EW-1 -: DATA_W];
    assign rd_instr      = rd_entry_q[2*DATA_W -: DATA_W];
    assign rd_result     = rd_entry_q[DATA_W -: DATA_W];
    assign rd_has_result = rd_entry_q[0];
    assign state_o       = state_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign orphan_cnt    = orphan_q;

endmodule

// File: tb/tb_pdp11_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pdp11_trace_buffer
//
// Directed bench for pdp11_trace_buffer (DATA_W=16, DEPTH=8, POST_TRIG=3):
// stop-when-full, wrap with overflow, opcode trigger, unpaired fetches and
// orphan results, simultaneous fetch/result, and reset during POST.
// -----------------------------------------------------------------------------
module tb_pdp11_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic        stop;
    logic        mode;
    logic        trig_en;
    logic [15:0] trig_mask;
    logic [15:0] trig_value;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic [15:0] fetch_instr;
    logic        result_valid;
    logic [15:0] alu_result;
    logic        rd_en;
    logic        rd_valid;
    logic [15:0] rd_pc;
    logic [15:0] rd_instr;
    logic [15:0] rd_result;
    logic        rd_has_result;
    logic [1:0]  state_o;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  orphan_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] MOV = 16'o010000;
    localparam logic [15:0] ADD = 16'o060000;

    pdp11_trace_buffer #(
        .DATA_W    (16),
        .DEPTH     (8),
        .POST_TRIG (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .arm           (arm),
        .stop          (stop),
        .mode          (mode),
        .trig_en       (trig_en),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .result_valid  (result_valid),
        .alu_result    (alu_result),
        .rd_en         (rd_en),
        .rd_valid      (rd_valid),
        .rd_pc         (rd_pc),
        .rd_instr      (rd_instr),
        .rd_result     (rd_result),
        .rd_has_result (rd_has_result),
        .state_o       (state_o),
        .count         (count),
        .overflow      (overflow),
        .orphan_cnt    (orphan_cnt)
    );

    always #5 clock = ~clock;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic m, input logic te);
        mode = m; trig_en = te; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] pc, input logic [15:0] instr);
        fetch_valid = 1'b1; fetch_pc = pc; fetch_instr = instr;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic do_result(input logic [15:0] res);
        result_valid = 1'b1; alu_result = res;
        tick();
        result_valid = 1'b0;
    endtask

    task automatic pair(input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] res);
        do_fetch(pc, instr);
        do_result(res);
    endtask

    task automatic read_entry(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                              input logic [15:0] res, input logic has);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_pc"}, rd_pc, pc);
        check({tag, "_instr"}, rd_instr, instr);
        check({tag, "_result"}, rd_result, res);
        check({tag, "_has"}, rd_has_result, has);
        $display("read %s: pc=%0d instr=%o result=%0d has=%0b", tag, rd_pc, rd_instr, rd_result, rd_has_result);
    endtask

    task automatic read_none(input string tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_novalid"}, rd_valid, 0);
        $display("read %s: rd_valid=%0b", tag, rd_valid);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; mode = 1'b0; trig_en = 1'b0;
        trig_mask = 16'o170000; trig_value = ADD;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        result_valid = 1'b0; alu_result = '0; rd_en = 1'b0;

        // ---------------- Reset state ----------------
        tick(); tick();
        reset = 1'b0;
        check("rst_state", state_o, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_orphan", orphan_cnt, 0);
        $display("reset: state=%0d count=%0d", state_o, count);

        // ---------------- Stop when full ----------------
        do_arm(1'b1, 1'b0);
        check("full_armed", state_o, 1);
        for (int i = 0; i < 8; i++) begin
            pair(16'(i), MOV | 16'(i), 16'(10 * i));
            $display("full pair pc=%0d: state=%0d count=%0d", i, state_o, count);
            if (i == 6) check("full_before_last", state_o, 1);
        end
        check("full_state", state_o, 3);
        check("full_count", count, 8);
        check("full_overflow", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            read_entry($sformatf("full_rd%0d", i), 16'(i), MOV | 16'(i), 16'(10 * i), 1'b1);
        end
        tick();
        check("full_pulse", rd_valid, 0);
        read_none("full_rd8");

        // ---------------- Wrap with overflow ----------------
        do_arm(1'b0, 1'b0);
        check("wrap_armed", state_o, 1);
        check("wrap_count_clr", count, 0);
        for (int i = 0; i <= 10; i++) begin
            pair(16'(i), MOV | 16'(i), 16'(10 * i));
        end
        do_stop();
        check("wrap_state", state_o, 3);
        check("wrap_overflow", overflow, 1);
        check("wrap_count", count, 8);
        for (int i = 3; i <= 10; i++) begin
            read_entry($sformatf("wrap_rd%0d", i), 16'(i), MOV | 16'(i), 16'(10 * i), 1'b1);
        end
        read_none("wrap_rd_end");

        // ---------------- Opcode trigger ----------------
        do_arm(1'b0, 1'b1);
        check("trig_overflow_clr", overflow, 0);
        pair(16'd100, MOV | 16'o0001, 16'd1);
        pair(16'd101, MOV | 16'o0002, 16'd2);
        check("trig_pre_state", state_o, 1);
        do_fetch(16'd102, ADD | 16'o0102);
        check("trig_post_entered", state_o, 2);
        $display("trigger fetch: state=%0d count=%0d", state_o, count);
        do_result(16'd3);
        pair(16'd103, MOV | 16'o0003, 16'd4);
        check("trig_still_post", state_o, 2);
        pair(16'd104, MOV | 16'o0004, 16'd5);
        check("trig_done", state_o, 3);
        pair(16'd105, MOV | 16'o0005, 16'd6);
        check("trig_count", count, 5);
        read_entry("trig_rd0", 16'd100, MOV | 16'o0001, 16'd1, 1'b1);
        read_entry("trig_rd1", 16'd101, MOV | 16'o0002, 16'd2, 1'b1);
        read_entry("trig_rd2", 16'd102, ADD | 16'o0102, 16'd3, 1'b1);
        read_entry("trig_rd3", 16'd103, MOV | 16'o0003, 16'd4, 1'b1);
        read_entry("trig_rd4", 16'd104, MOV | 16'o0004, 16'd5, 1'b1);
        read_none("trig_rd5");

        // ---------------- Unpaired fetch and orphan result ----------------
        do_arm(1'b0, 1'b0);
        do_fetch(16'd200, MOV | 16'o0200);
        do_fetch(16'd201, MOV | 16'o0201);
        do_result(16'h0055);
        do_result(16'h0066);
        check("orph_cnt", orphan_cnt, 1);
        check("orph_count", count, 2);
        do_stop();
        read_entry("orph_rd0", 16'd200, MOV | 16'o0200, 16'h0000, 1'b0);
        read_entry("orph_rd1", 16'd201, MOV | 16'o0201, 16'h0055, 1'b1);
        read_none("orph_rd2");

        // ---------------- Simultaneous fetch and result ----------------
        do_arm(1'b0, 1'b0);
        check("sim_orphan_clr", orphan_cnt, 0);
        do_fetch(16'd300, MOV | 16'o0300);
        fetch_valid = 1'b1; fetch_pc = 16'd301; fetch_instr = MOV | 16'o0301;
        result_valid = 1'b1; alu_result = 16'h0030;
        tick();
        fetch_valid = 1'b0; result_valid = 1'b0;
        check("sim_count1", count, 1);
        do_result(16'h0031);
        check("sim_count2", count, 2);
        check("sim_orphan", orphan_cnt, 0);
        do_stop();
        read_entry("sim_rd0", 16'd300, MOV | 16'o0300, 16'h0030, 1'b1);
        read_entry("sim_rd1", 16'd301, MOV | 16'o0301, 16'h0031, 1'b1);
        read_none("sim_rd2");

        // ---------------- Reset during POST ----------------
        do_arm(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pair(16'(400 + i), MOV | 16'(i), 16'(i));
        end
        do_fetch(16'd404, ADD);
        do_result(16'd9);
        check("rp_state_post", state_o, 2);
        check("rp_count5", count, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rp_state", state_o, 0);
        check("rp_count", count, 0);
        check("rp_overflow", overflow, 0);
        check("rp_rd_valid", rd_valid, 0);
        $display("reset in POST: state=%0d count=%0d", state_o, count);
        read_none("rp_rd_idle");
        check("rp_state_after_rd", state_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
